fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR controller. It drives a single multiply-accumulate unit through an NTAPS-deep sample history and a run-time programmable coefficient bank, one tap per clock. It gives a valid/ready-streamed alternative to the fully parallel 21-tap filter, for sample rates at or below sys_clk/(NTAPS+2). Coefficients are written through a simple register port by the configuration master.

---
 rtl/fir_mac_sequencer_if.sv | 32 +++
 rtl/fir_mac_sequencer.sv | 81 ++++++++
 tb/tb_fir_mac_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: sample/result stream, coefficient write port and status of the FIR MAC sequencer.
//   in_data/in_valid/in_ready    : input sample stream (master -> slave)
//   out_data/out_valid/out_ready : filtered result stream (slave -> master)
//   coef_we/coef_addr/coef_data  : coefficient write port, addr 0 = newest sample tap
//   hist_clr                     : flush of the sample history
//   busy                         : sequencer is not idle
interface fir_mac_sequencer_if #(
  parameter int NTAPS = 21,
  parameter int DW    = 16,
  parameter int CW    = 16
);
  localparam int AW = $clog2(NTAPS);
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 hist_clr;
  logic                 busy;
  modport master (
    output in_data, in_valid, out_ready, coef_we, coef_addr, coef_data, hist_clr,
    input  in_ready, out_data, out_valid, busy
  );
  modport slave (
    input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_data, hist_clr,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR, one multiply-accumulate per clock over an NTAPS-deep history.
//   sys_clk   : clock, all state on rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : slave side of fir_mac_sequencer_if (sample in, result out, coefficient port, hist_clr, busy)
module fir_mac_sequencer #(
  parameter int NTAPS = 21,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACC_W = 36,
  parameter int QFRAC = 15
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  fir_mac_sequencer_if.slave  bus
);
  localparam int AW = $clog2(NTAPS);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t                  r_state, w_next;
  logic signed [DW-1:0]    r_hist [NTAPS];
  logic signed [CW-1:0]    r_coef [NTAPS];
  logic signed [ACC_W-1:0] r_acc;
  logic [AW-1:0]           r_k, r_rd, r_wr_ptr;
  logic                    w_idle, w_accept, w_clr, w_coef_wr;
  logic [AW-1:0]           w_wp;
  logic signed [DW+CW-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  assign w_idle    = r_state == IDLE;
  assign w_accept  = w_idle && bus.in_valid;
  assign w_clr     = w_idle && bus.hist_clr;
  // a coincident clear restarts the history, so the accepted sample lands in slot 0
  assign w_wp      = w_clr ? '0 : r_wr_ptr;
  assign w_coef_wr = w_idle && bus.coef_we && ({1'b0, bus.coef_addr} < (AW+1)'(NTAPS));
  assign w_prod     = (DW+CW)'(r_coef[r_k]) * (DW+CW)'(r_hist[r_rd]);
  assign w_prod_ext = ACC_W'(w_prod);
  assign bus.in_ready  = w_idle;
  assign bus.busy      = !w_idle;
  assign bus.out_valid = r_state == OUT;
  assign bus.out_data  = r_acc[QFRAC+DW-1:QFRAC];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.in_valid ? MAC : IDLE;
      MAC:     w_next = (r_k == LAST) ? OUT : MAC;
      OUT:     w_next = bus.out_ready ? IDLE : OUT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_k      <= '0;
      r_rd     <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_wr_ptr <= '0;
        for (int i = 0; i < NTAPS; i++) r_hist[i] <= '0;
      end
      if (w_coef_wr) r_coef[bus.coef_addr] <= bus.coef_data;
      if (w_accept) begin
        r_hist[w_wp] <= bus.in_data;
        r_wr_ptr     <= (w_wp == LAST) ? '0 : w_wp + 1'b1;
        r_rd         <= w_wp;
        r_acc        <= '0;
        r_k          <= '0;
      end else if (r_state == MAC) begin
        // r_rd walks backwards from the newest sample: x[n-k]
        r_acc <= r_acc + w_prod_ext;
        r_k   <= (r_k == LAST) ? '0 : r_k + 1'b1;
        r_rd  <= (r_rd == '0) ? LAST : r_rd - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed self-checking bench for fir_mac_sequencer.
module tb_fir_mac_sequencer;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic signed [15:0] cset [21];
  logic signed [15:0] half [11];
  logic signed [15:0] res;
  logic signed [15:0] exp_v;
  int lat;
  always #5 sys_clk = ~sys_clk;
  fir_mac_sequencer_if #(.NTAPS(21), .DW(16), .CW(16)) bus ();
  fir_mac_sequencer #(.NTAPS(21), .DW(16), .CW(16), .ACC_W(36), .QFRAC(15)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus)
  );
  task automatic write_coef(input logic [4:0] a, input logic signed [15:0] d);
    @(negedge sys_clk);
    bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
    @(posedge sys_clk); #1;
    bus.coef_we = 1'b0;
  endtask
  task automatic load_coefs();
    for (int i = 0; i < 21; i++) write_coef(5'(i), cset[i]);
  endtask
  task automatic clear_hist();
    @(negedge sys_clk);
    bus.hist_clr = 1'b1;
    @(posedge sys_clk); #1;
    bus.hist_clr = 1'b0;
  endtask
  // one full transaction with out_ready=1; lat = edge count from accept to the handshake edge
  task automatic run_sample(input logic signed [15:0] d, input logic clr, input logic we,
                            input logic [4:0] a, input logic signed [15:0] cd,
                            output logic signed [15:0] r, output int l);
    @(negedge sys_clk);
    bus.in_data = d; bus.in_valid = 1'b1; bus.hist_clr = clr;
    bus.coef_we = we; bus.coef_addr = a; bus.coef_data = cd;
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0; bus.hist_clr = 1'b0; bus.coef_we = 1'b0;
    l = 1;
    while (l < 100) begin
      @(negedge sys_clk);
      if (bus.out_valid) break;
      l++;
    end
    if (l >= 100) begin
      total++; bad++;
      $display("FAIL timeout waiting out_valid got none want high within 100 cycles");
    end
    r = bus.out_data;
    @(posedge sys_clk); #1;
  endtask
  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    total++; if (bus.out_data !== 16'sd0) begin bad++; $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
  endtask
  task automatic test_impulse();
    for (int i = 0; i < 21; i++) cset[i] = 16'sd0;
    cset[0] = 16'sd1135; cset[10] = 16'sd27889;
    load_coefs();
    for (int i = 0; i < 21; i++) begin
      run_sample((i == 0) ? 16'sd16384 : 16'sd0, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
      exp_v = (i == 0) ? 16'sd567 : (i == 10) ? 16'sd13944 : 16'sd0;
      total++; if (res !== exp_v) begin bad++; $display("FAIL impulse[%0d] out_data got %0d want %0d", i, res, exp_v); end
      total++; if (lat != 22) begin bad++; $display("FAIL impulse_latency[%0d] got %0d want 22", i, lat); end
    end
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL back_to_back in_ready/out_valid got %b/%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask
  task automatic test_dc_wrap();
    half = '{16'sd1135, 16'sd512, 16'sd364, 16'sd46, 16'sd1406, 16'sd2625,
             16'sd5777, 16'sd4839, 16'sd12231, 16'sd11695, 16'sd27889};
    for (int i = 0; i < 21; i++) cset[i] = half[(i <= 10) ? i : 20 - i];
    load_coefs();
    for (int i = 0; i < 21; i++) begin
      run_sample(16'sd16384, i == 0, 1'b0, 5'd0, 16'sd0, res, lat);
      if (i == 0) begin
        total++; if (res !== 16'sd567) begin bad++; $display("FAIL dc_first got %0d want 567", res); end
      end
      if (i == 10) begin
        total++; if (res !== -16'sd31277) begin bad++; $display("FAIL dc_eleventh got %0d want -31277", res); end
      end
    end
    total++; if (res !== -16'sd10962) begin bad++; $display("FAIL dc_wrap got %0d want -10962", res); end
  endtask
  task automatic test_sign();
    for (int i = 0; i < 21; i++) cset[i] = 16'sd0;
    cset[0] = 16'sd1;
    load_coefs();
    run_sample(-16'sd32768, 1'b1, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== -16'sd1) begin bad++; $display("FAIL sign_min got %0d want -1", res); end
    run_sample(16'sd1, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== 16'sd0) begin bad++; $display("FAIL sign_plus1 got %0d want 0", res); end
    run_sample(-16'sd1, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== -16'sd1) begin bad++; $display("FAIL sign_minus1 got %0d want -1", res); end
  endtask
  task automatic test_backpressure();
    int n;
    bus.out_ready = 1'b0;
    @(negedge sys_clk);
    bus.in_data = -16'sd32768; bus.in_valid = 1'b1;
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge sys_clk); n++; end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_timeout got %b want 1", bus.out_valid); end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'sd1234;
      @(posedge sys_clk);
      @(negedge sys_clk);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, bus.out_valid); end
      total++; if (bus.out_data !== -16'sd1) begin bad++; $display("FAIL bp_hold_data[%0d] got %0d want -1", i, bus.out_data); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge sys_clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
  endtask
  task automatic test_config();
    int n;
    write_coef(5'd0, 16'sd100);
    @(negedge sys_clk);
    bus.in_data = 16'sd16384; bus.in_valid = 1'b1; bus.hist_clr = 1'b1;
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0; bus.hist_clr = 1'b0;
    repeat (3) @(negedge sys_clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL cfg_busy got %b want 1", bus.busy); end
    bus.coef_we = 1'b1; bus.coef_addr = 5'd0; bus.coef_data = 16'sd500;
    @(posedge sys_clk); #1;
    bus.coef_we = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge sys_clk); n++; end
    total++; if (bus.out_data !== 16'sd50) begin bad++; $display("FAIL cfg_dropped_in_mac got %0d want 50", bus.out_data); end
    @(posedge sys_clk); #1;
    run_sample(16'sd16384, 1'b0, 1'b1, 5'd0, 16'sd500, res, lat);
    total++; if (res !== 16'sd250) begin bad++; $display("FAIL cfg_same_edge got %0d want 250", res); end
    write_coef(5'd21, 16'sd999);
    write_coef(5'd31, 16'sd999);
    run_sample(16'sd16384, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== 16'sd250) begin bad++; $display("FAIL cfg_out_of_range got %0d want 250", res); end
  endtask
  task automatic test_reset_clear();
    for (int i = 0; i < 21; i++) cset[i] = 16'sd0;
    cset[0] = 16'sd1135; cset[1] = 16'sd2000; cset[20] = 16'sd4000;
    load_coefs();
    run_sample(16'sd16384, 1'b1, 1'b0, 5'd0, 16'sd0, res, lat);
    run_sample(16'sd16384, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    @(negedge sys_clk);
    bus.in_data = 16'sd16384; bus.in_valid = 1'b1;
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got %b want 1", bus.busy); end
    #1 sys_rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got %b want 0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got %b want 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready got %b want 1", bus.in_ready); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_sample(16'sd16384, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== 16'sd0) begin bad++; $display("FAIL rst_coefs_zero got %0d want 0", res); end
    load_coefs();
    run_sample(16'sd16384, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    run_sample(16'sd16384, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    clear_hist();
    run_sample(16'sd16384, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== 16'sd567) begin bad++; $display("FAIL clr_impulse got %0d want 567", res); end
    run_sample(16'sd0, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== 16'sd1000) begin bad++; $display("FAIL clr_next got %0d want 1000", res); end
    run_sample(16'sd16384, 1'b1, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== 16'sd567) begin bad++; $display("FAIL clr_coincident got %0d want 567", res); end
    run_sample(16'sd0, 1'b0, 1'b0, 5'd0, 16'sd0, res, lat);
    total++; if (res !== 16'sd1000) begin bad++; $display("FAIL clr_coincident_next got %0d want 1000", res); end
  endtask
  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.hist_clr = 1'b0;
    test_reset();
    test_impulse();
    test_dc_wrap();
    test_sign();
    test_backpressure();
    test_config();
    test_reset_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
